fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Sequences the instruction-memory read port for the core.
- Maintains the fetch PC and issues word reads to a fixed-latency instruction memory.
- Buffers returned words in a small in-order queue and hands them to decode with a valid/ready handshake.
- Handles branch redirects and raises `fetch_complete` once the program end is reached and fully drained; the top level exposes `pc` and `fetch_complete` to benches.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- QDEPTH, 4, instruction queue entries (power of two, 2..16).
- MEM_LATENCY, 1, cycles from `imem_req` to valid `imem_rdata` (1..4).
- MAX_PC, 32'h0000_0400, byte address at or above which no fetch is issued.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- imem_req  out  1  read request this cycle; memory always accepts.
- imem_addr  out  XLEN  word-aligned read address (equals `pc` when `imem_req`=1).
- imem_rdata  in  XLEN  read data, valid MEM_LATENCY cycles after the matching `imem_req`.
- redirect_valid  in  1  one-cycle pulse: flush and restart at `redirect_pc`.
- redirect_pc  in  XLEN  redirect target; bits[1:0] ignored (forced 0).
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode accepts head.
- inst_data  out  XLEN  head instruction word.
- inst_pc  out  XLEN  address of head instruction.
- pc  out  XLEN  next fetch address.
- fetch_complete  out  1  program fully fetched and drained.

Behaviour:
- Reset values:
  - `pc`=RESET_PC.
  - `imem_req`=0, `imem_addr`=0.
  - `inst_valid`=0, `inst_data`=0, `inst_pc`=0.
  - `fetch_complete`=0.
  - Queue empty, in-flight count 0, state RUN.
- Reset asserted mid-operation discards the queue and all in-flight reads immediately. Data returning after reset deasserts is ignored, because the in-flight shift pipe is cleared.
- Issue rule:
  - In RUN, `imem_req`=1 iff `pc`<MAX_PC and (occupancy + in_flight) < QDEPTH and no redirect this cycle.
  - On issue, `pc` += 4.
  - With this rule the queue can never overflow; an overflow is a design error.
- Return path:
  - A MEM_LATENCY-deep shift pipe carries valid, kill bit and PC alongside each request.
  - A returning entry that is not killed is enqueued with its PC.
- Dequeue: on `inst_valid`&&`inst_ready`. Enqueue and dequeue in the same cycle are both performed and occupancy is unchanged.
- Head visibility: `inst_valid` is registered and asserts the cycle after enqueue into an empty queue. Minimum request-to-`inst_valid` latency is MEM_LATENCY+1.
- End marker: a returned word equal to 32'h0000_0000 is NOT enqueued. It kills all younger in-flight reads, stops issue, and moves the state to DRAIN.
- State RUN:
  - → DRAIN on end marker.
  - → DRAIN when `pc`>=MAX_PC and in_flight=0.
- State DRAIN: no issue; → DONE when the queue is empty and in_flight=0.
- State DONE: `fetch_complete`=1 (registered); no issue; held until reset or redirect.
- Redirect (any state):
  - Queue flushed and `inst_valid`=0 next cycle.
  - All in-flight reads killed.
  - `pc`=`redirect_pc` & ~3.
  - State RUN, `fetch_complete`=0.
  - No issue in the redirect cycle; issue resumes the following cycle.
- Priority: a redirect beats an end marker or dequeue in the same cycle; a dequeue in the redirect cycle is still accepted by decode but the rest of the queue is lost.
- PC arithmetic: unsigned modulo 2^XLEN. Wrap to 0 is allowed only if MAX_PC permits.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds internal 32-bit saturating counters `perf_issue_cnt` (cycles with `imem_req`=1) and `perf_stall_cnt` (cycles with `inst_valid`&&!`inst_ready`).
  - Both counters clear on reset only, not on redirect.
  - Benches read them hierarchically.
- Undefined: counters absent; port list and all other behaviour identical.

Test Plan:
- Reset, memory holds words 0x13,0x93,0x113 at 0x0,0x4,0x8 then 0 at 0xC, `inst_ready`=1 → `inst_data` sequence 0x13,0x93,0x113 with `inst_pc` 0,4,8; `fetch_complete`=1 after the queue empties; `pc` stops at 0x10 or less.
- Hold `inst_ready`=0, QDEPTH=4 → exactly 4 requests issued, `imem_req` low thereafter; release `inst_ready` → issue resumes one request per freed slot, order preserved.
- Pulse `redirect_valid` with `redirect_pc`=0x42 while 3 entries are queued and 1 is in flight → next cycle `inst_valid`=0, `pc`=0x40; the first delivered instruction has `inst_pc`=0x40; stale data is never delivered.
- MAX_PC=0x10, memory holds no zero word → requests for 0x0..0xC only; after draining 4 instructions, `fetch_complete`=1.
- Assert `reset` asynchronously mid-burst (between clock edges) → all outputs take reset values immediately; after deassert, fetch restarts at RESET_PC.
- With FETCH_PERF_EN, run the backpressure case → `perf_issue_cnt`=4 and `perf_stall_cnt` equals the number of cycles `inst_valid` was held with `inst_ready`=0.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory read port, branch redirect and decode handshake bundle
interface fetch_sequencer_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencing, fixed-latency imem reads, in-order queue with redirect/end handling; FETCH_PERF_EN adds perf counters
module fetch_sequencer #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              QDEPTH      = 4,
  parameter int              MEM_LATENCY = 1,
  parameter logic [XLEN-1:0] MAX_PC      = 'h400
) (
  input  logic             clk,
  input  logic             reset,
  fetch_sequencer_if.master bus,
  output logic [XLEN-1:0]  pc,
  output logic             fetch_complete
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] q_data [QDEPTH];
  logic [XLEN-1:0] q_pc [QDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [MEM_LATENCY-1:0] p_v, p_k;
  logic [MEM_LATENCY-1:0][XLEN-1:0] p_pc;
  logic [5:0] in_flight;
  logic ret_live, end_mark, enq, deq, issue;
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) in_flight = in_flight + 6'(p_v[i] & ~p_k[i]);
  end
  assign ret_live = p_v[MEM_LATENCY-1] & ~p_k[MEM_LATENCY-1];
  assign end_mark = ret_live && bus.imem_rdata == '0;
  assign enq = ret_live && bus.imem_rdata != '0 && !bus.redirect_valid;
  assign deq = bus.inst_valid && bus.inst_ready;
  // reset gates issue combinationally so imem_req drops the instant reset rises
  always_comb begin
    issue = !reset && state == RUN && pc < MAX_PC && (6'(count) + in_flight < 6'(QDEPTH))
            && !bus.redirect_valid && !end_mark;
    state_nx = bus.redirect_valid ? RUN :
               (state == RUN && (end_mark || (pc >= MAX_PC && in_flight == '0))) ? DRAIN :
               (state == DRAIN && count == '0 && in_flight == '0) ? DONE : state;
  end
  assign bus.imem_req = issue;
  assign bus.imem_addr = issue ? pc : '0;
  assign bus.inst_valid = count != '0;
  assign bus.inst_data = q_data[rd_ptr];
  assign bus.inst_pc = q_pc[rd_ptr];
  assign fetch_complete = state == DONE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      pc <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      p_v <= '0;
      p_k <= '0;
      p_pc <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i] <= '0;
      end
    end else begin
      state <= state_nx;
      pc <= bus.redirect_valid ? bus.redirect_pc & ~XLEN'(3) : issue ? pc + XLEN'(4) : pc;
      p_v <= (p_v << 1) | MEM_LATENCY'(issue);
      p_k <= (p_k << 1) | {MEM_LATENCY{bus.redirect_valid | end_mark}};
      p_pc <= (p_pc << XLEN) | (MEM_LATENCY*XLEN)'(pc);
      if (bus.redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (enq) begin
          q_data[wr_ptr] <= bus.imem_rdata;
          q_pc[wr_ptr] <= p_pc[MEM_LATENCY-1];
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (deq) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(enq) - CW'(deq);
      end
    end
  end
`ifdef FETCH_PERF_EN
  logic [31:0] perf_issue_cnt, perf_stall_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue && ~&perf_issue_cnt) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (bus.inst_valid && !bus.inst_ready && ~&perf_stall_cnt) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus with a queue scoreboard checked by an independent delivery monitor
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] pc;
  logic fetch_complete;
  fetch_sequencer_if #(.XLEN(32)) bus();
  fetch_sequencer #(
    .XLEN(32), .RESET_PC(32'h0), .QDEPTH(4), .MEM_LATENCY(1), .MAX_PC(32'h60)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .pc(pc), .fetch_complete(fetch_complete)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [31:0] pc; logic [31:0] data;} exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_pass = 0;
  int req_cnt = 0;
  logic [31:0] mem [64];
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endfunction
  // single-cycle-latency instruction memory
  always @(posedge clk) if (bus.imem_req) bus.imem_rdata <= mem[bus.imem_addr[7:2]];
  always @(negedge clk) if (!reset && bus.imem_req) req_cnt++;
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.inst_valid && bus.inst_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_extra: got inst_pc %h data %h, required no delivery", bus.inst_pc, bus.inst_data);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", bus.inst_pc, e.pc);
        chk("sb_data", bus.inst_data, e.data);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(logic [31:0] a, logic [31:0] d);
    sb.push_back({a, d});
  endtask
  task automatic push_run(int first, int n);
    for (int i = first; i < first + n; i++) push(32'(4 * i), 32'h13 + 32'h80 * 32'(i));
  endtask
  task automatic wait_done(string name);
    int i = 0;
    while (!fetch_complete && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk(name, 32'(fetch_complete), 32'd1);
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask
  task automatic check_reset(string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_imem_req"}, 32'(bus.imem_req), 32'd0);
    chk({tag, "_imem_addr"}, bus.imem_addr, 32'h0);
    chk({tag, "_inst_valid"}, 32'(bus.inst_valid), 32'd0);
    chk({tag, "_inst_data"}, bus.inst_data, 32'h0);
    chk({tag, "_inst_pc"}, bus.inst_pc, 32'h0);
    chk({tag, "_fetch_complete"}, 32'(fetch_complete), 32'd0);
  endtask
  initial begin
    int r0;
`ifdef FETCH_PERF_EN
    logic [31:0] pi0, ps0;
`endif
    for (int i = 0; i < 64; i++) mem[i] = 32'h13 + 32'h80 * 32'(i);
    mem[3] = 32'h0;
    mem[18] = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    check_reset("rst");
    // program 0x13,0x93,0x113 then end marker at 0xC
    push(32'h0, 32'h13);
    push(32'h4, 32'h93);
    push(32'h8, 32'h113);
    step();
    reset = 1'b0;
    wait_done("prog_done");
    chk("prog_pc_stop", pc, 32'h10);
    chk("prog_valid_low", 32'(bus.inst_valid), 32'd0);
    // backpressure from 0x20 with decode stalled
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h20;
    bus.inst_ready = 1'b0;
    r0 = req_cnt;
`ifdef FETCH_PERF_EN
    pi0 = dut.perf_issue_cnt;
    ps0 = dut.perf_stall_cnt;
`endif
    step();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("bp_pc_start", pc, 32'h20);
    chk("bp_valid0", 32'(bus.inst_valid), 32'd0);
    repeat (9) step();
    @(negedge clk);
    chk("bp_reqs", 32'(req_cnt - r0), 32'd4);
    chk("bp_req_low", 32'(bus.imem_req), 32'd0);
    chk("bp_head_pc", bus.inst_pc, 32'h20);
    chk("bp_pc_hold", pc, 32'h30);
`ifdef FETCH_PERF_EN
    chk("perf_issue", dut.perf_issue_cnt - pi0, 32'd4);
`endif
    push_run(8, 10);
    step();
    bus.inst_ready = 1'b1;
    wait_done("bp_done");
`ifdef FETCH_PERF_EN
    chk("perf_stall", dut.perf_stall_cnt - ps0, 32'd8);
`endif
    // redirect to 0x42 with three queued and one returning
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h20;
    bus.inst_ready = 1'b0;
    step();
    bus.redirect_valid = 1'b0;
    repeat (4) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h42;
    step();
    bus.redirect_valid = 1'b0;
    bus.inst_ready = 1'b1;
    push(32'h40, 32'h813);
    push(32'h44, 32'h893);
    @(negedge clk);
    chk("rd_valid_flushed", 32'(bus.inst_valid), 32'd0);
    chk("rd_pc", pc, 32'h40);
    chk("rd_req_resume", 32'(bus.imem_req), 32'd1);
    chk("rd_addr", bus.imem_addr, 32'h40);
    wait_done("rd_done");
    // run into MAX_PC with no end marker
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h50;
    r0 = req_cnt;
    push_run(20, 4);
    step();
    bus.redirect_valid = 1'b0;
    wait_done("max_done");
    chk("max_reqs", 32'(req_cnt - r0), 32'd4);
    chk("max_pc", pc, 32'h60);
    // asynchronous reset mid-burst
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h20;
    bus.inst_ready = 1'b0;
    step();
    bus.redirect_valid = 1'b0;
    repeat (2) step();
    #2;
    reset = 1'b1;
    #1;
    check_reset("arst");
    step();
    #2;
    bus.inst_ready = 1'b1;
    push(32'h0, 32'h13);
    push(32'h4, 32'h93);
    push(32'h8, 32'h113);
    reset = 1'b0;
    #1;
    chk("arst_restart_req", 32'(bus.imem_req), 32'd1);
    chk("arst_restart_addr", bus.imem_addr, 32'h0);
    wait_done("arst_done");
    chk("arst_pc_stop", pc, 32'h10);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
